wavelet_frame_ctrl: RTL and testbench
=====================================

Name: wavelet_frame_ctrl

Overview:
Frame-level sequencer in front of the wavelet baseline-removal pipeline (16 lanes per beat, fixed pipeline latency TOTAL_DELAY+1). On a start command it clears the pipeline history and admits exactly cfg_frame_len input beats from an upstream valid/ready source. It then counts returning output beats, masks the warm-up transient, measures pipeline latency, and reports completion or error. It carries control plus input data only; output data bypasses this block.

Parameters:
DATA_WIDTH, 16, bits per sample
LANES, 16, samples per beat
TOTAL_DELAY, 154, datapath latency; expected measured latency is TOTAL_DELAY+1
CLEAR_CYC, 4, cycles dp_clear is held in CLEAR
TIMEOUT_MARGIN, 64, extra silent cycles tolerated in DRAIN
LEN_W, 16, frame-length counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle frame start request
cfg_frame_len  in  LEN_W  beats per frame, sampled on accepted start
cfg_discard  in  LEN_W  leading output beats to mask, sampled on accepted start
s_valid  in  1  upstream beat valid
s_ready  out  1  upstream ready
s_data  in  DATA_WIDTH*LANES  upstream beat
dp_clear  out  1  pipeline clear to datapath, active-high
dp_din_valid  out  1  beat valid to datapath
dp_din  out  DATA_WIDTH*LANES  beat to datapath
dp_out_valid  in  1  datapath output beat valid
m_keep  out  1  output beat qualifies (post warm-up)
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err_timeout  out  1  sticky, drain timed out
err_count  out  1  sticky, unexpected output beat
latency  out  LEN_W  cycles from first dp_din_valid to first dp_out_valid
out_count  out  LEN_W  output beats seen this frame

Behaviour:
- Reset: state IDLE; s_ready, dp_din_valid, m_keep, busy, done, err_* = 0; dp_din, latency, out_count, all internal counters = 0. dp_clear = rst OR (state==CLEAR).
- Reset mid-frame aborts immediately; no done pulse.
- States:
  - IDLE: start accepted only here; start elsewhere ignored. On accept, latch len and discard, clear err_*, out_count and latency. If len==0, go to DONE; else go to CLEAR.
  - CLEAR: dp_clear=1 for exactly CLEAR_CYC cycles, then go to FEED.
  - FEED: s_ready = 1 (combinational, state==FEED). Each s_valid&s_ready registers s_data into dp_din and sets dp_din_valid=1 on the next cycle; otherwise dp_din_valid=0 and dp_din holds. The in-count increments per accepted beat. Acceptance of beat len moves to DRAIN, so s_ready is 0 from the next cycle.
  - DRAIN: wait until out_count==len, then go to DONE. A silence counter resets on each dp_out_valid. When it reaches TOTAL_DELAY+1+TIMEOUT_MARGIN, set err_timeout and go to DONE. If the last expected beat and the timeout land in the same cycle, completion wins and err_timeout stays 0.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: the counter loads 1 on the cycle the first dp_din_valid is high and increments each cycle after. latency captures the counter value on the first dp_out_valid of the frame, then holds until the next start.
- Output counting: in FEED or DRAIN, when dp_out_valid and out_count<len, out_count increments. m_keep = dp_out_valid & (out_count >= discard) & (out_count < len), combinational, evaluated on the pre-increment count.
- A dp_out_valid in IDLE, CLEAR or DONE, or with out_count==len, sets err_count; out_count is unchanged.
- discard >= len: m_keep never asserts; the frame still completes normally.
- busy = (state != IDLE), including the DONE cycle.

Test Plan:
- len=10, discard=2, s_valid continuously high, delay-line model of 155 cycles → 4 dp_clear cycles; 10 consecutive dp_din_valid; latency=155; out_count=10; m_keep on beats 3..10 (8 beats); one done pulse; err_*=0.
- len=5, s_valid high every other cycle, data 0x0001..0x0005 per lane → dp_din_valid mirrors the gaps one cycle later with matching data; s_ready drops the cycle after beat 5 is accepted; done fires.
- len=10, model drops the last output beat → err_timeout=1 after 155+64 silent cycles; out_count=9; done pulses; err_count=0.
- dp_out_valid pulsed while IDLE → err_count=1; next start clears it to 0; a clean frame then completes with no errors.
- start asserted during FEED is ignored (counts unchanged); rst raised mid-FEED → next cycle state IDLE, s_ready=0, dp_clear=1 while rst is high, out_count=0, no done pulse.
- start with len=0 → no CLEAR and s_ready never asserts; done pulses one cycle after start; busy high for exactly that one cycle.

Source files
------------

// File: rtl/wavelet_frame_ctrl.sv
// Frame sequencer for the wavelet baseline-removal pipeline: clears history, admits cfg_frame_len beats, tracks returning beats.
// Latency: input beat is registered onto dp_din one cycle after the s_valid/s_ready handshake; status flags update one cycle after the event.
// Backpressure: s_ready is high only while feeding; the datapath output side has no backpressure and is only counted here.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, cfg_frame_len,    frame start request with its beat count and
//   cfg_discard              number of leading output beats to mask
//   s_valid/s_ready/s_data   upstream input beat handshake
//   dp_clear, dp_din_valid,  pipeline clear and registered beat to datapath
//   dp_din
//   dp_out_valid             datapath output beat strobe
//   m_keep                   current output beat is past the warm-up window
//   busy, done               frame in progress / one-cycle completion pulse
//   err_timeout, err_count   sticky drain timeout / unexpected output beat
//   latency, out_count       measured pipeline latency / output beats seen
module wavelet_frame_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int LANES          = 16,
  parameter int TOTAL_DELAY    = 154,
  parameter int CLEAR_CYC      = 4,
  parameter int TIMEOUT_MARGIN = 64,
  parameter int LEN_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LEN_W-1:0]              cfg_frame_len,
  input  logic [LEN_W-1:0]              cfg_discard,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH*LANES-1:0]   s_data,
  output logic                          dp_clear,
  output logic                          dp_din_valid,
  output logic [DATA_WIDTH*LANES-1:0]   dp_din,
  input  logic                          dp_out_valid,
  output logic                          m_keep,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic                          err_count,
  output logic [LEN_W-1:0]              latency,
  output logic [LEN_W-1:0]              out_count
);

  // Silence allowed in DRAIN: one full pipeline transit plus margin.
  localparam int SIL_LIMIT = TOTAL_DELAY + 1 + TIMEOUT_MARGIN;
  localparam int SIL_W     = $clog2(SIL_LIMIT + 1);
  localparam int CLR_W     = $clog2(CLEAR_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] disc_q;
  logic [LEN_W-1:0] in_cnt;
  logic [LEN_W-1:0] lat_cnt;
  logic [CLR_W-1:0] clr_cnt;
  logic [SIL_W-1:0] sil_cnt;
  logic             lat_run;
  logic             lat_got;

  logic start_acc;
  logic accept;
  logic in_frame;
  logic complete;
  logic timeout;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    dp_clear  = rst;
    start_acc = 1'b0;
    accept    = 1'b0;
    in_frame  = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    m_keep    = 1'b0;
    case (state)
      S_IDLE: begin
        start_acc = start;
        if (start) state_nx = (cfg_frame_len == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        busy     = 1'b1;
        dp_clear = 1'b1;
        if (clr_cnt == CLR_W'(CLEAR_CYC - 1)) state_nx = S_FEED;
      end
      S_FEED: begin
        busy     = 1'b1;
        s_ready  = 1'b1;
        in_frame = 1'b1;
        accept   = s_valid;
        if (s_valid && (in_cnt == len_q - 1'b1)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy     = 1'b1;
        in_frame = 1'b1;
        // A frame that completes on the same cycle the silence limit is hit is not a timeout.
        complete = (out_count == len_q);
        timeout  = !complete && (sil_cnt == SIL_W'(SIL_LIMIT));
        if (complete || timeout) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Judged on the count before this beat is added.
    m_keep = in_frame && dp_out_valid && (out_count >= disc_q) && (out_count < len_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= '0;
      disc_q       <= '0;
      in_cnt       <= '0;
      lat_cnt      <= '0;
      clr_cnt      <= '0;
      sil_cnt      <= '0;
      lat_run      <= 1'b0;
      lat_got      <= 1'b0;
      dp_din       <= '0;
      dp_din_valid <= 1'b0;
      err_timeout  <= 1'b0;
      err_count    <= 1'b0;
      latency      <= '0;
      out_count    <= '0;
    end else begin
      dp_din_valid <= 1'b0;
      clr_cnt      <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
      sil_cnt      <= (state == S_DRAIN && !dp_out_valid) ? sil_cnt + 1'b1 : '0;

      if (start_acc) begin
        len_q       <= cfg_frame_len;
        disc_q      <= cfg_discard;
        in_cnt      <= '0;
        lat_cnt     <= '0;
        lat_run     <= 1'b0;
        lat_got     <= 1'b0;
        err_timeout <= 1'b0;
        err_count   <= 1'b0;
        latency     <= '0;
        out_count   <= '0;
      end

      if (accept) begin
        dp_din       <= s_data;
        dp_din_valid <= 1'b1;
        in_cnt       <= in_cnt + 1'b1;
      end

      if (timeout) err_timeout <= 1'b1;

      // Latency counter starts at 1 on the first input beat to the datapath and
      // saturates rather than wrapping on a very long stall.
      if (in_frame) begin
        if (dp_din_valid && !lat_run) begin
          lat_run <= 1'b1;
          lat_cnt <= {{(LEN_W-1){1'b0}}, 1'b1};
        end else if (lat_run && (lat_cnt != '1)) begin
          lat_cnt <= lat_cnt + 1'b1;
        end
        if (dp_out_valid && !lat_got) begin
          latency <= lat_cnt;
          lat_got <= 1'b1;
        end
      end

      // Any output beat outside the counting window is unexpected.
      if (dp_out_valid) begin
        if (in_frame && (out_count < len_q)) out_count <= out_count + 1'b1;
        else                                 err_count <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wavelet_frame_ctrl.sv
`timescale 1ns/1ps
module tb_wavelet_frame_ctrl;
  localparam int DW    = 16;
  localparam int LN    = 16;
  localparam int TD    = 154;
  localparam int CC    = 4;
  localparam int TM    = 64;
  localparam int LW    = 16;
  localparam int BW    = DW * LN;
  localparam int DLY   = TD + 1;
  localparam int LIMIT = TD + 1 + TM;
  localparam int HN    = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_frame_len = '0;
  logic [LW-1:0] cfg_discard = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] s_data = '0;
  logic          dp_clear, dp_din_valid;
  logic [BW-1:0] dp_din;
  logic          dp_out_valid = 1'b0;
  logic          m_keep, busy, done, err_timeout, err_count;
  logic [LW-1:0] latency, out_count;

  wavelet_frame_ctrl #(
    .DATA_WIDTH(DW), .LANES(LN), .TOTAL_DELAY(TD), .CLEAR_CYC(CC),
    .TIMEOUT_MARGIN(TM), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_frame_len(cfg_frame_len),
    .cfg_discard(cfg_discard), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dp_clear(dp_clear), .dp_din_valid(dp_din_valid), .dp_din(dp_din),
    .dp_out_valid(dp_out_valid), .m_keep(m_keep), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_count(err_count), .latency(latency),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- stimulus-side state (written by the initial block only)
  int feed_mode = 0;   // 0 idle, 1 continuous, 2 every other cycle
  int drop_rel  = -1;  // index of the output beat the pipeline model loses
  bit inj_out   = 1'b0;
  bit cmp_en    = 1'b0;
  int b_clr, b_dinv, b_keep, b_done, b_rdy, b_busy, b_beat, b_dl;

  // ---------------- observation counters (written by the negedge block only)
  int n_clr = 0, n_dinv = 0, n_keep = 0, n_done = 0, n_rdy = 0, n_busy = 0;
  int beat_idx = 0, last_out = -1, done_cyc = -1;
  int din_cyc[$];
  int acc_cyc[$];
  logic [BW-1:0] din_q[$];
  bit hist[0:HN-1];
  bit rdy_hist[0:HN-1];

  // ---------------- upstream source
  always @(posedge clk) begin
    logic [DW-1:0] lv;
    #1;
    if (feed_mode == 1)      s_valid = 1'b1;
    else if (feed_mode == 2) s_valid = ~s_valid;
    else                     s_valid = 1'b0;
    lv     = DW'(beat_idx - b_beat + 1);
    s_data = {LN{lv}};
  end

  // ---------------- datapath model: fixed delay line of DLY cycles
  int dl_cnt = 0;
  always @(posedge clk) begin
    logic v;
    #2;
    v = inj_out;
    if (cyc >= DLY && cyc < HN && hist[cyc-DLY]) begin
      if ((dl_cnt - b_dl) != drop_rel) v = 1'b1;
      dl_cnt++;
    end
    dp_out_valid = v;
  end

  // ---------------- frame model and per-cycle compare
  typedef enum int {M_IDLE, M_CLEAR, M_FEED, M_DRAIN, M_DONE} mph_t;
  mph_t ph = M_IDLE;
  int m_len = 0, m_disc = 0, m_fed = 0, m_seen = 0, m_clear_left = 0;
  int m_quiet = 0, m_first = -1, m_lat = 0;
  bit m_latgot = 0, m_errT = 0, m_errC = 0, m_dinv = 0;
  logic [BW-1:0] m_din = '0;

  always @(negedge clk) begin
    bit in_frame, acc, e_keep, compl, tmo;
    in_frame = (ph == M_FEED) || (ph == M_DRAIN);
    e_keep   = dp_out_valid && in_frame && (m_seen >= m_disc) && (m_seen < m_len);
    if (cmp_en) begin
      check("s_ready",      s_ready,      ph == M_FEED);
      check("dp_clear",     dp_clear,     rst || (ph == M_CLEAR));
      check("dp_din_valid", dp_din_valid, m_dinv);
      check("dp_din",       dp_din,       m_din);
      check("m_keep",       m_keep,       e_keep);
      check("busy",         busy,         ph != M_IDLE);
      check("done",         done,         ph == M_DONE);
      check("err_timeout",  err_timeout,  m_errT);
      check("err_count",    err_count,    m_errC);
      check("out_count",    out_count,    LW'(m_seen));
      check("latency",      latency,      LW'(m_lat));
    end

    // observation
    if (dp_clear) n_clr++;
    if (dp_din_valid) begin n_dinv++; din_cyc.push_back(cyc); din_q.push_back(dp_din); end
    if (m_keep) n_keep++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (s_ready) n_rdy++;
    if (busy) n_busy++;
    if (dp_out_valid) last_out = cyc;
    if (s_valid && s_ready) begin beat_idx++; acc_cyc.push_back(cyc); end
    if (cyc < HN) begin
      rdy_hist[cyc] = s_ready;
      hist[cyc] = dp_din_valid;
      if (dp_clear) for (int k = 0; k < DLY; k++) if (cyc - k >= 0) hist[cyc-k] = 1'b0;
    end

    // model update for the coming edge
    if (rst) begin
      ph = M_IDLE; m_len = 0; m_disc = 0; m_fed = 0; m_seen = 0; m_first = -1;
      m_lat = 0; m_latgot = 0; m_errT = 0; m_errC = 0; m_dinv = 0; m_din = '0;
    end else begin
      acc   = (ph == M_FEED) && s_valid;
      compl = (ph == M_DRAIN) && (m_seen == m_len);
      tmo   = (ph == M_DRAIN) && !compl && ((cyc - m_quiet) == LIMIT);
      if (ph == M_IDLE && start) begin
        m_len = int'(cfg_frame_len); m_disc = int'(cfg_discard); m_fed = 0; m_seen = 0;
        m_first = -1; m_lat = 0; m_latgot = 0; m_errT = 0; m_errC = 0;
      end
      if (acc) begin m_din = s_data; m_fed++; end
      if (in_frame && dp_out_valid && !m_latgot) begin
        m_lat = (m_first < 0) ? 0 : cyc - m_first;
        m_latgot = 1;
      end
      if (in_frame && m_dinv && m_first < 0) m_first = cyc;
      if (dp_out_valid) begin
        if (in_frame && m_seen < m_len) m_seen++;
        else m_errC = 1;
      end
      if (tmo) m_errT = 1;
      if (ph == M_DRAIN && dp_out_valid) m_quiet = cyc + 1;
      m_dinv = acc;
      case (ph)
        M_IDLE:  if (start) begin ph = (m_len == 0) ? M_DONE : M_CLEAR; m_clear_left = CC; end
        M_CLEAR: begin m_clear_left--; if (m_clear_left == 0) ph = M_FEED; end
        M_FEED:  if (acc && m_fed == m_len) begin ph = M_DRAIN; m_quiet = cyc + 1; end
        M_DRAIN: if (compl || tmo) ph = M_DONE;
        default: ph = M_IDLE;
      endcase
    end
  end

  // ---------------- helpers
  task automatic snap();
    b_clr = n_clr; b_dinv = n_dinv; b_keep = n_keep; b_done = n_done;
    b_rdy = n_rdy; b_busy = n_busy; b_beat = beat_idx; b_dl = dl_cnt;
  endtask

  task automatic start_frame(input int len, input int disc);
    @(posedge clk); #1;
    cfg_frame_len = LW'(len); cfg_discard = LW'(disc); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while ((n_done - b_done) == 0 && k < budget) begin @(negedge clk); #1; k++; end
    check(name, (n_done - b_done) > 0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, span;
    logic [DW-1:0] lv;
    logic [BW-1:0] expd;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk); #1;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dp_clear", dp_clear, 1'b1);
    check("rst_dinv", dp_din_valid, 1'b0);
    check("rst_dp_din", dp_din, '0);
    check("rst_out_count", out_count, '0);
    check("rst_latency", latency, '0);
    check("rst_errs", {err_timeout, err_count, m_keep}, 3'b000);
    @(posedge clk); #1 rst = 1'b0;
    idle(3);

    // frame 1: len 10, discard 2, continuous input
    snap(); drop_rel = -1; feed_mode = 1;
    start_frame(10, 2);
    wait_done("t1_done_seen", 600);
    feed_mode = 0;
    idle(2);
    check("t1_clear_cycles", n_clr - b_clr, 4);
    check("t1_dinv_count", n_dinv - b_dinv, 10);
    span = (din_cyc.size() >= b_dinv + 10) ? din_cyc[b_dinv+9] - din_cyc[b_dinv] : -1;
    check("t1_dinv_span", span, 9);
    check("t1_latency", latency, 16'd155);
    check("t1_out_count", out_count, 16'd10);
    check("t1_keep_count", n_keep - b_keep, 8);
    check("t1_done_pulses", n_done - b_done, 1);
    check("t1_errs", {err_timeout, err_count}, 2'b00);

    // frame 2: len 5, input valid every other cycle
    snap(); feed_mode = 2;
    start_frame(5, 0);
    wait_done("t2_done_seen", 600);
    feed_mode = 0;
    idle(2);
    check("t2_dinv_count", n_dinv - b_dinv, 5);
    for (int i = 0; i < 5; i++) begin
      lv = DW'(i + 1);
      expd = {LN{lv}};
      check("t2_beat_data", (din_q.size() > b_dinv + i) ? din_q[b_dinv+i] : '0, expd);
    end
    span = (din_cyc.size() >= b_dinv + 5) ? din_cyc[b_dinv+4] - din_cyc[b_dinv] : -1;
    check("t2_dinv_span", span, 8);
    k = (acc_cyc.size() >= b_beat + 5) ? acc_cyc[b_beat+4] + 1 : 0;
    check("t2_ready_after_last", rdy_hist[k], 1'b0);
    check("t2_done_pulses", n_done - b_done, 1);

    // frame 3: pipeline loses its last output beat
    snap(); drop_rel = 9; feed_mode = 1;
    start_frame(10, 0);
    wait_done("t3_done_seen", 800);
    feed_mode = 0;
    idle(2);
    drop_rel = -1;
    check("t3_err_timeout", err_timeout, 1'b1);
    check("t3_err_count", err_count, 1'b0);
    check("t3_out_count", out_count, 16'd9);
    check("t3_done_pulses", n_done - b_done, 1);
    span = done_cyc - last_out;
    check("t3_silence_window", (span >= LIMIT) && (span <= LIMIT + 3), 1'b1);

    // stray output beat while idle, then a clean frame
    @(posedge clk); #1 inj_out = 1'b1;
    @(posedge clk); #1 inj_out = 1'b0;
    idle(2);
    check("t4_err_count_set", err_count, 1'b1);
    snap(); feed_mode = 1;
    start_frame(4, 1);
    check("t4_err_count_cleared", err_count, 1'b0);
    wait_done("t4_done_seen", 600);
    feed_mode = 0;
    idle(2);
    check("t4_errs", {err_timeout, err_count}, 2'b00);
    check("t4_out_count", out_count, 16'd4);
    check("t4_keep_count", n_keep - b_keep, 3);

    // start during FEED is ignored; reset mid-FEED aborts
    snap(); feed_mode = 1;
    start_frame(20, 0);
    k = 0;
    while ((beat_idx - b_beat) < 3 && k < 200) begin @(negedge clk); #1; k++; end
    check("t5_three_beats", (beat_idx - b_beat) >= 3, 1'b1);
    @(posedge clk); #1 cfg_frame_len = 16'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); #1;
    check("t5_still_feeding", {busy, s_ready}, 2'b11);
    k = 0;
    while ((beat_idx - b_beat) < 8 && k < 200) begin @(negedge clk); #1; k++; end
    check("t5_beyond_ignored_len", (beat_idx - b_beat) >= 8, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("t5_rst_s_ready", s_ready, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_dp_clear", dp_clear, 1'b1);
    check("t5_rst_out_count", out_count, '0);
    @(posedge clk); #1 rst = 1'b0; feed_mode = 0;
    idle(200);
    check("t5_no_done", n_done - b_done, 0);
    check("t5_no_err_count", err_count, 1'b0);

    // zero-length frame
    snap();
    start_frame(0, 0);
    @(negedge clk); #1;
    check("t6_done_now", {done, busy}, 2'b11);
    @(negedge clk); #1;
    check("t6_done_after", {done, busy}, 2'b00);
    idle(5);
    check("t6_busy_cycles", n_busy - b_busy, 1);
    check("t6_no_ready", n_rdy - b_rdy, 0);
    check("t6_no_clear", n_clr - b_clr, 0);
    check("t6_done_pulses", n_done - b_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
